// File: rtl/sq_idx_alloc_if.sv
// Bundle of the store-queue index allocator's request, free, squash and status signals.
// Dispatch owns the master side; the allocator owns the slave side.
interface sq_idx_alloc_if #(
    parameter int SIZE         = 64,
    parameter int ALLOC_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 2
);
    localparam int PW = $clog2(SIZE) + 1;
    localparam int DW = $clog2(COMMIT_WIDTH + 1);

    // Handshake: i_alloc_fire acts as valid and o_can_alloc as ready. A batch
    // transfers on a cycle where both are high and i_squash is low. o_can_alloc
    // is a registered signal and does not depend on fire or on the requests.
    logic [ALLOC_WIDTH-1:0]          i_alloc_req;
    logic                            i_alloc_fire;
    logic                            o_can_alloc;
    logic [ALLOC_WIDTH-1:0][PW-1:0]  o_alloc_idx;
    logic [DW-1:0]                   i_dealloc_cnt;
    logic                            i_squash;
    logic [PW-1:0]                   i_squash_idx;
    logic [PW-1:0]                   o_head;
    logic [PW-1:0]                   o_tail;
    logic [PW-1:0]                   o_count;
    logic                            o_empty;
    logic                            o_full;
    logic                            o_err;

    modport master (
        output i_alloc_req, i_alloc_fire, i_dealloc_cnt, i_squash, i_squash_idx,
        input  o_can_alloc, o_alloc_idx, o_head, o_tail, o_count, o_empty, o_full, o_err
    );

    modport slave (
        input  i_alloc_req, i_alloc_fire, i_dealloc_cnt, i_squash, i_squash_idx,
        output o_can_alloc, o_alloc_idx, o_head, o_tail, o_count, o_empty, o_full, o_err
    );
endinterface

// File: rtl/sq_idx_alloc.sv
// Circular store-queue index allocator: {flipped, idx} pointers, in-order frees,
// tail rollback on squash, and a sticky protocol-error flag.
module sq_idx_alloc #(
    parameter int SIZE         = 64,
    parameter int ALLOC_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 2
) (
    input logic          clk,
    input logic          rst,
    sq_idx_alloc_if.slave bus
);
    localparam int PW = $clog2(SIZE) + 1;
    localparam int DW = $clog2(COMMIT_WIDTH + 1);
    localparam logic [PW-1:0] CAN_LIMIT = PW'(SIZE - ALLOC_WIDTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          err;

    logic [PW-1:0] head_n;
    logic [PW-1:0] tail_n;
    logic          err_n;
    logic [PW-1:0] count;
    logic [PW-1:0] acc;
    logic [PW-1:0] alloc_n;
    logic [PW-1:0] dealloc_ext;
    logic [PW-1:0] free_n;
    logic [PW-1:0] squash_off;
    logic [PW-1:0] tail_off;
    logic          can_alloc;
    logic          over_free;
    logic          do_alloc;

    // The extra top bit makes plain subtraction give the occupancy mod 2*SIZE.
    assign count     = tail - head;
    assign can_alloc = (count <= CAN_LIMIT);

    // Each slot gets tail plus the number of requests in lower slots.
    always_comb begin
        acc = '0;
        bus.o_alloc_idx = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            bus.o_alloc_idx[k] = tail + acc;
            acc = acc + {{(PW-1){1'b0}}, bus.i_alloc_req[k]};
        end
        alloc_n = acc;
    end

    always_comb begin
        dealloc_ext = {{(PW-DW){1'b0}}, bus.i_dealloc_cnt};
        over_free   = (dealloc_ext > count);
        free_n      = over_free ? count : dealloc_ext;
        head_n      = head + free_n;
        do_alloc    = bus.i_alloc_fire && can_alloc && !bus.i_squash;
        squash_off  = bus.i_squash_idx - head_n;
        tail_off    = tail - head_n;
        tail_n      = tail;
        err_n       = err || over_free || (bus.i_alloc_fire && !can_alloc);
        if (bus.i_squash) begin
            // A squash point outside [new head, old tail] collapses the queue to empty.
            if (squash_off <= tail_off) begin
                tail_n = bus.i_squash_idx;
            end else begin
                tail_n = head_n;
                err_n  = 1'b1;
            end
        end else if (do_alloc) begin
            tail_n = tail + alloc_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            err  <= 1'b0;
        end else begin
            head <= head_n;
            tail <= tail_n;
            err  <= err_n;
        end
    end

    assign bus.o_can_alloc = can_alloc;
    assign bus.o_head      = head;
    assign bus.o_tail      = tail;
    assign bus.o_count     = count;
    assign bus.o_empty     = (head == tail);
    assign bus.o_full      = (head[PW-2:0] == tail[PW-2:0]) && (head[PW-1] != tail[PW-1]);
    assign bus.o_err       = err;
endmodule
